// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared definitions for the codec audio paths (DAC transmit and ADC capture).
//   DATA_LENGTH  : bits per channel; a FIFO word carries left in the MSBs and
//                  right in the LSBs.
//   audio_word_t : one stereo FIFO word.
//   tx_state_t   : DAC transmitter frame state.
package audio_pkg;

  localparam int DATA_LENGTH = 16;

  typedef logic [2*DATA_LENGTH-1:0] audio_word_t;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LEFT,
    RIGHT
  } tx_state_t;

endpackage

// File: rtl/lrck_edge_detector.sv
// lrck_edge_detector
//   Registers the codec LRCK on the bit clock and flags its transitions.
//   Ports:
//     AUD_BCLK : bit clock, rising edge
//     reset    : asynchronous, active-high
//     lrck     : LRCK from the codec (changes on falling AUD_BCLK)
//     rise     : high for the one cycle where lrck=1 and the registered copy is 0
//     fall     : high for the one cycle where lrck=0 and the registered copy is 1
module lrck_edge_detector (
  input  logic AUD_BCLK,
  input  logic reset,
  input  logic lrck,
  output logic rise,
  output logic fall
);

  logic lrck_d;

  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) lrck_d <= 1'b0;
    else       lrck_d <= lrck;
  end

  assign rise = lrck & ~lrck_d;
  assign fall = ~lrck & lrck_d;

endmodule

// File: rtl/audio_dac_transmitter.sv
// audio_dac_transmitter
//   Pops one stereo word per LRCK frame from a non-showahead playback FIFO and
//   shifts it out MSB-first in I2S format; the codec masters BCLK and LRCK.
//   Ports:
//     AUD_BCLK     : bit clock, the only clock (rising edge)
//     reset        : asynchronous, active-high
//     AUD_DAC_CLK  : LRCK, 1 = left, 0 = right
//     AUD_DAC_DATA : serial DAC data
//     rdempty_sig  : FIFO empty
//     rdreq_sig    : FIFO read request, one cycle per frame, never while empty
//     q_sig        : FIFO read data, valid the cycle after rdreq_sig
//     underrun_sig : one-cycle pulse when a fetch finds the FIFO empty
//   Build option AUDIO_TX_MUTE_ON_UNDERRUN_EN: when defined an underrun loads
//   silence; otherwise the previous word is repeated.
module audio_dac_transmitter #(
  parameter int DATA_LENGTH = audio_pkg::DATA_LENGTH
) (
  input  logic                     AUD_BCLK,
  input  logic                     reset,
  input  logic                     AUD_DAC_CLK,
  output logic                     AUD_DAC_DATA,
  input  logic                     rdempty_sig,
  output logic                     rdreq_sig,
  input  logic [2*DATA_LENGTH-1:0] q_sig,
  output logic                     underrun_sig
);

  import audio_pkg::*;

  localparam int WORD_W = 2 * DATA_LENGTH;
  localparam int CNT_W  = $clog2(DATA_LENGTH + 1);
  localparam int IDX_W  = $clog2(WORD_W);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t cnt_sat_inc(input cnt_t c);
    return (c == cnt_t'(DATA_LENGTH)) ? c : c + cnt_t'(1);
  endfunction

  tx_state_t         state, state_nxt;
  logic [WORD_W-1:0] shift_reg, shift_nxt;
  logic [WORD_W-1:0] next_sample, sample_nxt;
  cnt_t              bit_cnt, cnt_nxt;
  logic              data_nxt;
  logic              fetch;
  logic              fetch_vld_p1;
  logic [IDX_W-1:0]  bit_idx;
  logic              lrck_rise, lrck_fall;

  lrck_edge_detector u_lrck_edge (
    .AUD_BCLK (AUD_BCLK),
    .reset    (reset),
    .lrck     (AUD_DAC_CLK),
    .rise     (lrck_rise),
    .fall     (lrck_fall)
  );

  // Only fetch when the FIFO has data; an empty fetch becomes an underrun.
  assign rdreq_sig = fetch & ~rdempty_sig;

  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    sample_nxt = next_sample;
    cnt_nxt    = bit_cnt;
    data_nxt   = 1'b0;
    fetch      = 1'b0;
    // bit_cnt counts bits already sent in this channel, so it selects the next one.
    if (state == LEFT) bit_idx = IDX_W'(WORD_W - 1) - IDX_W'(bit_cnt);
    else               bit_idx = IDX_W'(DATA_LENGTH - 1) - IDX_W'(bit_cnt);

    unique case (state)
      WAIT_SYNC: begin
        if (lrck_fall) begin
          // First right frame after sync has no word loaded: park the counter
          // at its limit so the line stays low.
          fetch     = 1'b1;
          state_nxt = RIGHT;
          cnt_nxt   = cnt_t'(DATA_LENGTH);
        end
      end
      LEFT: begin
        if (lrck_fall) begin
          fetch     = 1'b1;
          state_nxt = RIGHT;
          data_nxt  = shift_reg[DATA_LENGTH-1];
          cnt_nxt   = cnt_t'(1);
        end else if (bit_cnt < cnt_t'(DATA_LENGTH)) begin
          data_nxt = shift_reg[bit_idx];
          cnt_nxt  = cnt_sat_inc(bit_cnt);
        end
      end
      RIGHT: begin
        if (lrck_rise) begin
          state_nxt = LEFT;
          shift_nxt = next_sample;
          data_nxt  = next_sample[WORD_W-1];
          cnt_nxt   = cnt_t'(1);
        end else if (bit_cnt < cnt_t'(DATA_LENGTH)) begin
          data_nxt = shift_reg[bit_idx];
          cnt_nxt  = cnt_sat_inc(bit_cnt);
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase

    // Stage p1: FIFO data from the previous cycle's request.
    if (fetch_vld_p1) begin
      sample_nxt = q_sig;
    end
`ifdef AUDIO_TX_MUTE_ON_UNDERRUN_EN
    else if (underrun_sig) begin
      sample_nxt = '0;
    end
`endif
  end

  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) begin
      state        <= WAIT_SYNC;
      shift_reg    <= '0;
      next_sample  <= '0;
      bit_cnt      <= '0;
      AUD_DAC_DATA <= 1'b0;
      fetch_vld_p1 <= 1'b0;
      underrun_sig <= 1'b0;
    end else begin
      state        <= state_nxt;
      shift_reg    <= shift_nxt;
      next_sample  <= sample_nxt;
      bit_cnt      <= cnt_nxt;
      AUD_DAC_DATA <= data_nxt;
      fetch_vld_p1 <= rdreq_sig;
      underrun_sig <= fetch & rdempty_sig;
    end
  end

endmodule

// File: tb/tb_audio_dac_transmitter.sv
module tb_audio_dac_transmitter;

  localparam int DL = 16;
  localparam int WW = 2 * DL;

  logic          AUD_BCLK;
  logic          reset;
  logic          AUD_DAC_CLK;
  logic          AUD_DAC_DATA;
  logic          rdempty_sig;
  logic          rdreq_sig;
  logic [WW-1:0] q_sig;
  logic          underrun_sig;

  audio_dac_transmitter #(.DATA_LENGTH(DL)) dut (
    .AUD_BCLK     (AUD_BCLK),
    .reset        (reset),
    .AUD_DAC_CLK  (AUD_DAC_CLK),
    .AUD_DAC_DATA (AUD_DAC_DATA),
    .rdempty_sig  (rdempty_sig),
    .rdreq_sig    (rdreq_sig),
    .q_sig        (q_sig),
    .underrun_sig (underrun_sig)
  );

  initial AUD_BCLK = 1'b0;
  always #5 AUD_BCLK = ~AUD_BCLK;

  typedef struct packed {
    logic data;
    logic rdreq;
    logic und;
  } exp_t;

  exp_t          sb[$];
  logic [WW-1:0] fifo[$];
  int            checks;
  int            errors;

  // Frame-level reference: 0 = unsynced, 1 = left, 2 = right
  int            m_state;
  int            m_k;
  logic          m_first_right;
  logic          m_lrd;
  logic [WW-1:0] m_active;
  logic [WW-1:0] m_pend;
  logic          rd_seen;
  logic          rst_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bit-clock cycle: compare what the previous drive predicted, then
  // drive LRCK/reset for this cycle and queue the prediction for it.
  task automatic tick(input logic lr, input logic rst);
    exp_t          e;
    logic          fe, re, exp_rd, exp_und, exp_d, popped;
    logic [WW-1:0] pw;
    @(negedge AUD_BCLK);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("dac_data", 32'(AUD_DAC_DATA), 32'(e.data));
      check("rdreq",    32'(rd_seen),      32'(e.rdreq));
      check("underrun", 32'(underrun_sig), 32'(e.und));
    end
    rdempty_sig = (fifo.size() == 0);
    AUD_DAC_CLK = lr;
    exp_rd  = 1'b0;
    exp_und = 1'b0;
    exp_d   = 1'b0;
    if (rst) begin
      reset    = 1'b1;
      m_state  = 0;
      m_active = '0;
      m_pend   = '0;
      m_lrd    = 1'b0;
      m_k      = 0;
    end else begin
      reset = 1'b0;
      fe    = !lr && m_lrd;
      re    = lr && !m_lrd;
      m_lrd = lr;
      if (fe && m_state != 2) begin
        if (fifo.size() > 0) begin
          exp_rd = 1'b1;
          m_pend = fifo[0];
        end else begin
          exp_und = 1'b1;
`ifdef AUDIO_TX_MUTE_ON_UNDERRUN_EN
          m_pend = '0;
`endif
        end
        m_first_right = (m_state == 0);
        m_state       = 2;
        m_k           = 0;
      end else if (re && m_state == 2) begin
        m_active = m_pend;
        m_state  = 1;
        m_k      = 0;
      end
      if (m_state == 1 && m_k < DL)
        exp_d = m_active[WW-1-m_k];
      else if (m_state == 2 && !m_first_right && m_k < DL)
        exp_d = m_active[DL-1-m_k];
      m_k++;
    end
    sb.push_back(exp_t'{exp_d, exp_rd, exp_und});
    #1;
    if (rst && !rst_prev) begin
      check("reset_data",     32'(AUD_DAC_DATA), 32'd0);
      check("reset_rdreq",    32'(rdreq_sig),    32'd0);
      check("reset_underrun", 32'(underrun_sig), 32'd0);
    end
    rst_prev = rst;
    #3;
    rd_seen = rdreq_sig;
    popped  = 1'b0;
    pw      = '0;
    if (rdreq_sig && fifo.size() > 0) begin
      popped = 1'b1;
      pw     = fifo.pop_front();
    end
    @(posedge AUD_BCLK);
    #1;
    if (popped) q_sig = pw;
  endtask

  task automatic chan(input logic lr, input int n);
    for (int i = 0; i < n; i++) tick(lr, 1'b0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    AUD_DAC_CLK   = 1'b0;
    rdempty_sig   = 1'b1;
    q_sig         = '0;
    m_state       = 0;
    m_k           = 0;
    m_first_right = 1'b1;
    m_lrd         = 1'b0;
    m_active      = '0;
    m_pend        = '0;
    rd_seen       = 1'b0;
    rst_prev      = 1'b0;

    // Reset, then a normal word followed by one that later underruns.
    repeat (3) tick(1'b0, 1'b1);
    fifo.push_back(32'hA5A5_3C3C);
    fifo.push_back(32'h1234_5678);
    chan(1'b1, 32);
    repeat (4) begin
      chan(1'b0, 32);
      chan(1'b1, 32);
    end

    // Back-to-back words.
    fifo.push_back(32'hFFFF_0000);
    fifo.push_back(32'h0000_FFFF);
    repeat (3) begin
      chan(1'b0, 32);
      chan(1'b1, 32);
    end

    // Short channel periods drop the LSBs.
    fifo.push_back(32'hC3A5_96F0);
    fifo.push_back(32'h5A5A_0FF0);
    repeat (3) begin
      chan(1'b0, 8);
      chan(1'b1, 8);
    end

    // Reset in the middle of a left frame, then resync.
    fifo.push_back(32'hBEEF_CAFE);
    fifo.push_back(32'h0F0F_F0F0);
    chan(1'b0, 32);
    for (int i = 0; i < 32; i++) tick(1'b1, (i >= 6 && i < 9));
    chan(1'b0, 32);
    chan(1'b1, 32);
    chan(1'b0, 32);
    chan(1'b1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_dac_transmitter.md
# audio_dac_transmitter

Serializes stereo samples from the playback FIFO onto the codec DAC data line. It is the transmit counterpart of the ADC capture path and uses the same 32-bit word format: the 16 MSBs hold the left channel and the 16 LSBs hold the right channel. It pops one word per LRCK frame from the FIFO read port. It drives `AUD_DAC_DATA` MSB-first in I2S format, with the codec as bit-clock and LRCK master.

## Interface
- `DATA_LENGTH`, default 16: bits per channel. The FIFO word is 2*`DATA_LENGTH` bits.

Ports:
- `AUD_BCLK` input 1: audio bit clock. This is the only clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `AUD_DAC_CLK` input 1: DAC LRCK. 1 = left channel, 0 = right channel. It changes on falling `AUD_BCLK`.
- `AUD_DAC_DATA` output 1: serial DAC data.
- `rdempty_sig` input 1: FIFO empty indicator.
- `rdreq_sig` output 1: FIFO read request. The FIFO is non-showahead, so `q_sig` is valid one cycle after the request.
- `q_sig` input 2*`DATA_LENGTH`: FIFO read data.
- `underrun_sig` output 1: one-cycle pulse when a fetch finds the FIFO empty.

## Operation
- `lrck_d` registers `AUD_DAC_CLK` every cycle.
  - Rising edge (RE): `AUD_DAC_CLK`=1 and `lrck_d`=0.
  - Falling edge (FE): `AUD_DAC_CLK`=0 and `lrck_d`=1.
- Registers:
  - `shift_reg` (32 bits)
  - `next_sample` (32 bits)
  - `bit_cnt` (5 bits, saturating at `DATA_LENGTH`)
- States: `WAIT_SYNC`, `LEFT`, `RIGHT`.
- `WAIT_SYNC`:
  - `AUD_DAC_DATA`=0 and RE is ignored.
  - On FE: perform a fetch, then go to `RIGHT`. Output during this first right frame is 0.
- `RIGHT` → `LEFT` on RE:
  - `shift_reg` <= `next_sample`.
  - `AUD_DAC_DATA` <= `next_sample`[31].
  - `bit_cnt` <= 1.
- `LEFT` → `RIGHT` on FE:
  - `AUD_DAC_DATA` <= `shift_reg`[15].
  - `bit_cnt` <= 1.
  - Perform a fetch.
- Within a channel, while `bit_cnt` < `DATA_LENGTH`, each cycle outputs the next lower bit (left: bits 30..16; right: bits 14..0) and increments `bit_cnt`. At `bit_cnt`=`DATA_LENGTH` the output is 0 until the next edge.
- Fetch, at the FE cycle (call it R0):
  - `rdreq_sig`=1 only if `rdempty_sig`=0. `rdreq_sig` is never asserted while empty.
  - At R1, `next_sample` <= `q_sig`.
  - If the FIFO was empty: `underrun_sig`=1 at R1 and `next_sample` follows the Configuration rule.
- Short channel periods (fewer than `DATA_LENGTH` cycles): the LSBs are dropped and the next edge reloads. This is not an error.
- Reset mid-frame immediately forces all outputs to 0 and the state to `WAIT_SYNC`. Resync occurs at the next FE.

## Timing
- Reset values:
  - `AUD_DAC_DATA`=0, `rdreq_sig`=0, `underrun_sig`=0
  - `next_sample`=0, `shift_reg`=0, `lrck_d`=0, `bit_cnt`=0
  - state `WAIT_SYNC`
- The MSB is valid after the first rising `AUD_BCLK` following an LRCK change, so the codec samples it on the second rising edge (I2S 1-bit delay).
- `rdreq_sig` is high for exactly one cycle per frame. `q_sig` is captured one cycle later.
- The first FIFO word appears on the line at the first RE after the first post-reset FE.

## Configuration
- `AUDIO_TX_MUTE_ON_UNDERRUN_EN`:
  - Defined: on underrun, `next_sample` <= 0 (silence).
  - Undefined: `next_sample` holds the previous word, so the last sample repeats.
- `underrun_sig` behaves identically in both cases.

## Structure
- Package `audio_pkg`:
  - `DATA_LENGTH` constant
  - `audio_word_t` (32-bit, left in MSBs)
  - `tx_state_t` enum (`WAIT_SYNC`, `LEFT`, `RIGHT`)
  - This package is shared with the ADC capture block.
- One sub-module, `lrck_edge_detector`: registers LRCK and outputs one-cycle `rise`/`fall` strobes.

## Test plan
- Reset, FIFO holds 0xA5A5_3C3C, LRCK at 32 BCLK per channel → `rdreq_sig` pulses at the first FE. The next left frame outputs 1010010110100101 MSB-first starting at RE cycle, then 0s. The right frame outputs 0011110000111100.
- FIFO empty at FE, previous word 0x1234_5678 → `rdreq_sig`=0 and `underrun_sig` pulses at R1.
  - Without the macro: 0x1234/0x5678 repeat.
  - With the macro: all zeros.
- 8 BCLK per channel with `DATA_LENGTH`=16 → left outputs bits 31..24 only. The right frame starts cleanly with bit 15.
- Reset asserted mid-left frame → `AUD_DAC_DATA`=0 immediately. No `rdreq_sig` until the next FE; output resumes after the following RE.
- Back-to-back words 0xFFFF_0000 then 0x0000_FFFF → exactly one `rdreq_sig` per frame, and the serial stream matches each word bit-exact.
